// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory handshake plus IF/ID-side signals of the fetch front end
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        hold_IF_ID;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic [31:0] pc_plus4;
    modport master (
        output imem_req, imem_addr, instruction, inst_pc, pc_plus4,
        input  imem_ack, imem_rdata, redirect, redirect_pc, hold_IF_ID
    );
    modport slave (
        input  imem_req, imem_addr, instruction, inst_pc, pc_plus4,
        output imem_ack, imem_rdata, redirect, redirect_pc, hold_IF_ID
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, single-outstanding imem fetcher and fetch queue; FETCH_BYPASS_EN forwards an ack straight to IF/ID when the queue is empty
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input logic          clk_i,
    input logic          rst_ni,
    fetch_unit_if.master bus
);
    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {IDLE, REQ, KILL} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_next;
    logic [PW-1:0] rd_q, wr_q;
    logic [31:0]   fetch_pc_q, fetch_pc_d, addr_q, addr_d;
    logic [31:0]   data_q [FQ_DEPTH];
    logic [31:0]   pc_q [FQ_DEPTH];
    logic [31:0]   rpc, head_pc;
    logic          empty, ack, byp, consume, pop, push, room;
    assign rpc      = bus.redirect_pc & ~32'd3;
    assign empty    = cnt_q == '0;
    assign ack      = state_q != IDLE && bus.imem_ack;
`ifdef FETCH_BYPASS_EN
    assign byp      = empty && state_q == REQ && bus.imem_ack && !bus.redirect;
`else
    assign byp      = 1'b0;
`endif
    assign consume  = byp && !bus.hold_IF_ID;
    assign pop      = !empty && !bus.hold_IF_ID && !bus.redirect;
    assign push     = state_q == REQ && bus.imem_ack && !bus.redirect && !consume;
    assign cnt_next = cnt_q + CW'(push) - CW'(pop);
    assign room     = cnt_next < CW'(FQ_DEPTH);
    assign head_pc          = byp ? addr_q : (empty ? 32'h0 : pc_q[rd_q]);
    assign bus.instruction  = byp ? bus.imem_rdata : (empty ? 32'h0 : data_q[rd_q]);
    assign bus.inst_pc      = head_pc;
    assign bus.pc_plus4     = head_pc + 32'd4;
    assign bus.imem_req     = state_q != IDLE;
    assign bus.imem_addr    = addr_q;
    // next request state: redirect overrides everything, KILL swallows the in-flight word
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        cnt_d      = cnt_next;
        if (bus.redirect) begin
            cnt_d      = '0;
            fetch_pc_d = rpc;
            if (state_q == IDLE || ack) begin
                state_d = REQ;
                addr_d  = rpc;
            end else begin
                state_d = KILL;
            end
        end else if (state_q == IDLE) begin
            if (room) begin
                state_d = REQ;
                addr_d  = fetch_pc_q;
            end
        end else if (ack && state_q == KILL) begin
            state_d = REQ;
            addr_d  = fetch_pc_q;
        end else if (ack) begin
            fetch_pc_d = addr_q + 32'd4;
            addr_d     = addr_q + 32'd4;
            state_d    = room ? REQ : IDLE;
        end
    end
    // control registers and queue pointers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            if (bus.redirect) begin
                rd_q <= '0;
                wr_q <= '0;
            end else begin
                rd_q <= rd_q + PW'(pop);
                wr_q <= wr_q + PW'(push);
            end
        end
    end
    // queue storage; contents are only visible while counted, so no reset is needed
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_q[wr_q] <= bus.imem_rdata;
            pc_q[wr_q]   <= addr_q;
        end
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Instruction-fetch front end of the 5-stage pipeline; produces the `instruction` word consumed by the IF/ID register.
- Owns the PC and issues word requests to instruction memory over a req/ack handshake, with one request outstanding at a time.
- Buffers returned words in a small fetch queue, honours the IF/ID hold, and on a taken branch/jump redirects the PC and discards wrong-path words.
- When the queue is empty it drives a 32'b0 NOP bubble.

## Interface
- `RESET_PC`, 32'h0000_0000, PC of the first fetch after reset.
- `FQ_DEPTH`, 2, fetch-queue entries (power of two, ≥2).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset. Asynchronous and active-low: assert asynchronously, release synchronously to `clk`.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  32  byte address of the requested word.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  fetched word, valid when `imem_ack`=1.
- `redirect`  in  1  taken branch/jump; the same signal drives IF/ID `flush`.
- `redirect_pc`  in  32  target PC, valid with `redirect`.
- `hold_IF_ID`  in  1  stall; when 1, IF/ID does not capture and the head entry is not consumed.
- `instruction`  out  32  head-of-queue word, or 32'b0 when empty.
- `inst_pc`  out  32  PC of `instruction`; 0 when empty.
- `pc_plus4`  out  32  `inst_pc`+4 (mod 2^32), for branch-target computation.

## Operation
- State machine:
  - IDLE: no request.
  - REQ: `imem_req`=1; the result will be pushed.
  - KILL: `imem_req`=1; the result will be dropped.
- Handshake:
  - While in REQ or KILL, `imem_req`=1 and `imem_addr` is held stable until the edge where `imem_ack`=1.
  - `imem_ack` is ignored in IDLE.
- Queue accounting: pop = queue not empty & `hold_IF_ID`=0 & `redirect`=0. `cnt_next` = cnt + push − pop.
- IDLE → REQ when `cnt_next` < FQ_DEPTH; `imem_addr` ← `fetch_pc`.
- REQ with ack, no redirect:
  - Push {rdata, `imem_addr`}; `fetch_pc` ← `imem_addr`+4.
  - If `cnt_next` < FQ_DEPTH, stay in REQ with `imem_addr` ← `imem_addr`+4 (back-to-back). Otherwise go to IDLE.
- Redirect (highest priority):
  - Queue cleared (cnt=0), no pop, no push; `fetch_pc` ← `redirect_pc`.
  - From IDLE: → REQ with `imem_addr` ← `redirect_pc`.
  - From REQ with no ack same cycle: → KILL.
  - From REQ with ack same cycle: data dropped; → REQ with `imem_addr` ← `redirect_pc`.
  - From KILL: stay in KILL (or → REQ at `redirect_pc` if ack).
- KILL with ack: data dropped; → REQ with `imem_addr` ← `fetch_pc`.
- `hold_IF_ID` together with `redirect`: redirect wins.
- `redirect_pc[1:0]` ≠ 0: bits [1:0] are forced to 0.
- PC arithmetic is 32-bit unsigned and wraps at 32'hFFFF_FFFC → 0.

## Timing
- Reset values:
  - State IDLE, cnt=0, `fetch_pc`=`imem_addr`=RESET_PC.
  - `imem_req`=0, `instruction`=0, `inst_pc`=0, `pc_plus4`=4.
- First edge after `rst` release: IDLE→REQ. `imem_req` rises in cycle 1.
- A zero-wait memory (ack in the first req cycle) sustains one word per cycle.
- Fetch latency (no bypass): ack at edge N → word on `instruction` in cycle N+1 → captured by IF/ID at edge N+2.
- `instruction`, `inst_pc` and `pc_plus4` are combinational from queue registers only (no memory input path), except as described under bypass.
- Reset asserted mid-request: state returns to reset values immediately; any later ack is ignored in IDLE.

## Configuration
- Macro: `FETCH_BYPASS_EN`.
- Defined: when cnt=0, state=REQ, `imem_ack`=1 and `redirect`=0:
  - `instruction`=`imem_rdata` and `inst_pc`=`imem_addr` combinationally.
  - If `hold_IF_ID`=0 the word is consumed and not pushed; otherwise it is pushed.
  - Fetch latency drops by one cycle.
- Undefined: outputs come from queue registers only.

## Test plan
- Reset release, RESET_PC=0x100, ack every cycle, hold=0 → addrs 0x100, 0x104, 0x108…; `instruction` follows one per cycle starting cycle 2 (cycle 1 with `FETCH_BYPASS_EN`).
- hold_IF_ID=1 for 4 cycles with queue full → `imem_req` drops to 0, head stays at the same word/PC. On release, words resume in order with none lost or duplicated.
- Redirect to 0x400 while REQ at 0x10C is waiting (ack 2 cycles later, data 0xDEAD_BEEF) → state KILL, 0xDEAD_BEEF never appears on `instruction`, next `imem_addr`=0x400, `instruction`=0 until 0x400 returns.
- Redirect to 0x200 on the same edge as an ack at 0x10C → data dropped, queue empty, next `imem_addr`=0x200.
- Redirect together with hold=1 → queue flushed; redirect wins.
- redirect_pc=0x203 → `imem_addr`=0x200.
- `fetch_pc`=0xFFFF_FFFC → next addr 0x0000_0000.
- Assert rst mid-wait → `imem_req`=0 at once; a late ack is ignored.
